// File: rtl/output_uart_tx.sv
// -----------------------------------------------------------------------------
// output_uart_tx
//
// Captures every value latched into the output register into a small FIFO and
// sends each one to the host as an 8N1 UART frame (start, DATA_WIDTH data bits
// LSB first, stop). Back-to-back frames are sent with no idle gap between them.
//
// Optional feature macro: OUT_TX_PARITY_EN
//   When defined, an even-parity bit is sent between the last data bit and the
//   stop bit. The frame becomes (DATA_WIDTH+3)*CLKS_PER_BIT cycles long.
//
// Ports:
//   clk          system clock, rising-edge
//   reset        asynchronous active-low reset
//   out_load_i   output-register load strobe (one cycle per new value)
//   out_data_i   value being latched, sampled when out_load_i=1
//   tx_o         UART serial line, idle high, driven from a register
//   busy_o       frame in flight or FIFO non-empty
//   fifo_full_o  FIFO holds FIFO_DEPTH entries
//   overflow_o   sticky: a capture was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module output_uart_tx #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  out_load_i,
   input  logic [DATA_WIDTH-1:0] out_data_i,
   output logic                  tx_o,
   output logic                  busy_o,
   output logic                  fifo_full_o,
   output logic                  overflow_o
);

   localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
   localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_WIDTH - 1);
   localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } state_e;

   state_e                state_q, state_d;
   logic [BaudW-1:0]      baud_q, baud_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
`ifdef OUT_TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]       count_q;
   logic                  overflow_q;

   logic                  pop;
   logic                  push;
   logic                  full;
   logic                  baud_wrap;
   logic [DATA_WIDTH-1:0] head;

   assign full      = (count_q == CntFull);
   assign baud_wrap = (baud_q == BaudLast);
   assign head      = mem_q[rd_ptr_q];
   // A pop on the same edge frees a slot, so a full FIFO can still accept.
   assign push      = out_load_i & (~full | pop);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
`ifdef OUT_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
`ifdef OUT_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
`ifdef OUT_TX_PARITY_EN
      parity_d = parity_q;
`endif
      pop      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               pop      = 1'b1;
               shift_d  = head;
`ifdef OUT_TX_PARITY_EN
               parity_d = ^head;
`endif
               state_d  = StStart;
               tx_d     = 1'b0;
               baud_d   = '0;
               bit_d    = '0;
            end
         end

         StStart: begin
            if (baud_wrap) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end

         StData: begin
            if (baud_wrap) begin
               baud_d = '0;
               if (bit_q == BitLast) begin
`ifdef OUT_TX_PARITY_EN
                  state_d = StParity;
                  tx_d    = parity_q;
`else
                  state_d = StStop;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d   = bit_q + BitW'(1);
                  shift_d = shift_q >> 1;
                  tx_d    = shift_d[0];
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end

`ifdef OUT_TX_PARITY_EN
         StParity: begin
            if (baud_wrap) begin
               baud_d  = '0;
               state_d = StStop;
               tx_d    = 1'b1;
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
`endif

         StStop: begin
            if (baud_wrap) begin
               baud_d = '0;
               // Chain straight into the next frame when more data is queued.
               if (count_q != '0) begin
                  pop      = 1'b1;
                  shift_d  = head;
`ifdef OUT_TX_PARITY_EN
                  parity_d = ^head;
`endif
                  bit_d    = '0;
                  state_d  = StStart;
                  tx_d     = 1'b0;
               end else begin
                  state_d = StIdle;
                  tx_d    = 1'b1;
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end

         default: begin
            state_d = StIdle;
            baud_d  = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   // --------------------------------------------------------------- FIFO
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            count_q <= count_q + CntW'(1);
         end else if (pop && !push) begin
            count_q <= count_q - CntW'(1);
         end
         if (out_load_i && full && !pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Storage needs no reset: reset empties the FIFO through the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= out_data_i;
      end
   end

   assign tx_o        = tx_q;
   assign busy_o      = (state_q != StIdle) || (count_q != '0);
   assign fifo_full_o = full;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_output_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_output_uart_tx
//
// Directed bench for output_uart_tx (default build, 8N1, CLKS_PER_BIT=4,
// FIFO_DEPTH=4). Single-frame vectors come from a table of hand-written
// frames; back-to-back, overflow and asynchronous reset are hand sequences.
// -----------------------------------------------------------------------------
module tb_output_uart_tx;

   logic       clk;
   logic       reset;
   logic       out_load_i;
   logic [7:0] out_data_i;
   logic       tx_o;
   logic       busy_o;
   logic       fifo_full_o;
   logic       overflow_o;

   int n_tests = 0;
   int n_fail  = 0;

   output_uart_tx #(
      .DATA_WIDTH  (8),
      .CLKS_PER_BIT(4),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .out_load_i (out_load_i),
      .out_data_i (out_data_i),
      .tx_o       (tx_o),
      .busy_o     (busy_o),
      .fifo_full_o(fifo_full_o),
      .overflow_o (overflow_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;   // byte pushed
      logic [9:0] frame;  // expected line bits, [0] = start bit sent first
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Called at the negedge right after frame-start edge S plus 'start' cycles.
   // Samples each bit one cycle into its slot and returns at the negedge after
   // edge S+40, the earliest possible start of a following frame.
   task automatic check_frame(input string nm, input logic [9:0] frame,
                              input logic [7:0] exp_byte, input int start);
      logic [7:0] got;
      int         k;
      got = '0;
      for (int c = start + 1; c <= 40; c++) begin
         @(negedge clk);
         if ((c % 4 == 1) && (c <= 37)) begin
            k = (c - 1) / 4;
            check($sformatf("%s bit%0d", nm, k), 32'(tx_o), 32'(frame[k]));
            if (k >= 1 && k <= 8) got[k-1] = tx_o;
         end
         if (c == 39) check($sformatf("%s busy in stop", nm), 32'(busy_o), 32'd1);
      end
      check($sformatf("%s decoded", nm), 32'(got), 32'(exp_byte));
   endtask

   // Drive one load strobe; returns at the negedge after the load edge.
   task automatic push_one(input logic [7:0] d);
      out_load_i = 1'b1;
      out_data_i = d;
      @(negedge clk);
      out_load_i = 1'b0;
   endtask

   vec_t vecs [5];
   logic seen_low;

   initial begin
      vecs[0] = '{data: 8'h01, frame: 10'b1000000010};
      vecs[1] = '{data: 8'hA5, frame: 10'b1101001010};
      vecs[2] = '{data: 8'h3C, frame: 10'b1001111000};
      vecs[3] = '{data: 8'h00, frame: 10'b1000000000};
      vecs[4] = '{data: 8'h80, frame: 10'b1100000000};

      reset      = 1'b0;
      out_load_i = 1'b0;
      out_data_i = 8'h00;
      #12;
      check("reset tx", 32'(tx_o), 32'd1);
      check("reset busy", 32'(busy_o), 32'd0);
      check("reset full", 32'(fifo_full_o), 32'd0);
      check("reset overflow", 32'(overflow_o), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Single frames from the table.
      for (int i = 0; i < 5; i++) begin
         push_one(vecs[i].data);
         check($sformatf("v%0d busy after push", i), 32'(busy_o), 32'd1);
         check($sformatf("v%0d idle before start", i), 32'(tx_o), 32'd1);
         @(negedge clk);
         check($sformatf("v%0d start edge", i), 32'(tx_o), 32'd0);
         check_frame($sformatf("v%0d", i), vecs[i].frame, vecs[i].data, 0);
         check($sformatf("v%0d busy end", i), 32'(busy_o), 32'd0);
         check($sformatf("v%0d tx end", i), 32'(tx_o), 32'd1);
         check($sformatf("v%0d overflow", i), 32'(overflow_o), 32'd0);
         @(negedge clk);
      end

      // Back-to-back: no idle gap between stop and next start.
      out_load_i = 1'b1;
      out_data_i = 8'hA5;
      @(negedge clk);
      out_data_i = 8'h3C;
      @(negedge clk);
      out_load_i = 1'b0;
      check_frame("b2b A5", 10'b1101001010, 8'hA5, 0);
      check("b2b gap", 32'(tx_o), 32'd0);
      check_frame("b2b 3C", 10'b1001111000, 8'h3C, 0);
      check("b2b busy end", 32'(busy_o), 32'd0);
      @(negedge clk);

      // Overflow: six loads into a 4-deep FIFO, 0x10 popped at edge 1.
      for (int i = 0; i < 6; i++) begin
         if (i == 4) check("ovf full edge3", 32'(fifo_full_o), 32'd0);
         if (i == 5) begin
            check("ovf full edge4", 32'(fifo_full_o), 32'd1);
            check("ovf flag edge4", 32'(overflow_o), 32'd0);
         end
         out_load_i = 1'b1;
         out_data_i = 8'h10 + 8'(i);
         @(negedge clk);
      end
      out_load_i = 1'b0;
      check("ovf flag edge5", 32'(overflow_o), 32'd1);
      check("ovf full edge5", 32'(fifo_full_o), 32'd1);
      check_frame("ovf 10", 10'b1000100000, 8'h10, 4);
      check("ovf full after pop", 32'(fifo_full_o), 32'd0);
      check("ovf sticky", 32'(overflow_o), 32'd1);
      check_frame("ovf 11", 10'b1000100010, 8'h11, 0);
      check_frame("ovf 12", 10'b1000100100, 8'h12, 0);
      check_frame("ovf 13", 10'b1000100110, 8'h13, 0);
      check_frame("ovf 14", 10'b1000101000, 8'h14, 0);
      check("ovf busy end", 32'(busy_o), 32'd0);
      check("ovf still sticky", 32'(overflow_o), 32'd1);
      @(negedge clk);

      // Reset during data bit 3 of 0xFF with 0x00 still queued.
      out_load_i = 1'b1;
      out_data_i = 8'hFF;
      @(negedge clk);
      out_data_i = 8'h00;
      @(negedge clk);
      out_load_i = 1'b0;
      repeat (17) @(negedge clk);
      check("rst mid busy before", 32'(busy_o), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("rst mid tx", 32'(tx_o), 32'd1);
      check("rst mid busy", 32'(busy_o), 32'd0);
      check("rst mid full", 32'(fifo_full_o), 32'd0);
      check("rst mid overflow", 32'(overflow_o), 32'd0);
      @(negedge clk);
      reset    = 1'b1;
      seen_low = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (tx_o == 1'b0 || busy_o == 1'b1) seen_low = 1'b1;
      end
      check("rst no residual frame", 32'(seen_low), 32'd0);

      // Reset during a start bit must raise tx_o before the next edge.
      push_one(8'h00);
      repeat (3) @(negedge clk);
      check("rst start tx low", 32'(tx_o), 32'd0);
      #1 reset = 1'b0;
      #1;
      check("rst start tx async", 32'(tx_o), 32'd1);
      check("rst start busy", 32'(busy_o), 32'd0);
      @(negedge clk);
      reset    = 1'b1;
      seen_low = 1'b0;
      repeat (50) begin
         @(negedge clk);
         if (tx_o == 1'b0) seen_low = 1'b1;
      end
      check("rst start no residual", 32'(seen_low), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/output_uart_tx.md
Name: output_uart_tx

Overview:
- Serial transmitter on the far side of the output port.
- Captures every byte the computer latches into its output register and buffers it in a small FIFO.
- Sends each byte to the host as an 8N1 UART frame, so programs using OUTA are observable off-chip.
- Sits beside the output register at top level, fed by the output-register load strobe and data bus.

Parameters:
DATA_WIDTH, 8, width of output-register data and of each UART data field
CLKS_PER_BIT, 4, clk cycles per UART bit; integer >= 2
FIFO_DEPTH, 4, entries in the capture FIFO; power of two, >= 2

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset (0 asserts); clears all state immediately
out_load_i  input  1  high for one cycle when the output register latches a new value
out_data_i  input  DATA_WIDTH  value being latched into the output register (sampled when out_load_i=1)
tx_o  output  1  UART serial line, idle high
busy_o  output  1  high while a frame is in flight or the FIFO is non-empty
fifo_full_o  output  1  FIFO holds FIFO_DEPTH entries
overflow_o  output  1  sticky: a capture was dropped because the FIFO was full

Behaviour:
- Reset values: tx_o=1, busy_o=0, fifo_full_o=0, overflow_o=0. FIFO pointers, count, bit counter and baud counter = 0. FSM = IDLE.
- Reset is asynchronous: asserting it mid-frame forces tx_o high without waiting for a clock edge and discards FIFO contents.
- Push:
  - on posedge with out_load_i=1 and (FIFO not full OR a pop occurs on the same edge), write out_data_i.
  - If full and no pop on that edge, drop the data and set overflow_o; it stays set until reset.
- FSM states: IDLE, START, DATA, STOP. tx_o is driven from a register.
  - IDLE: if FIFO non-empty at the edge, pop the head into the shift register, go to START, tx_o=0. A byte pushed at edge N starts at edge N+1.
  - START: hold tx_o=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: shift out DATA_WIDTH bits, LSB first, each for CLKS_PER_BIT cycles.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. On the last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Frame length: (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
- Baud counter:
  - counts 0..CLKS_PER_BIT-1 and wraps;
  - the bit index advances only on wrap;
  - the bit index wraps at DATA_WIDTH-1 into STOP.
- FIFO: circular buffer with read/write pointers modulo FIFO_DEPTH and a count 0..FIFO_DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
  - A pop from an empty FIFO never occurs.
- busy_o = (state != IDLE) OR (count != 0). fifo_full_o = (count == FIFO_DEPTH). Both are combinational from registered state.

Optional Feature:
- Macro: OUT_TX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and transmits even parity (XOR of data bits) for CLKS_PER_BIT cycles. Frame length becomes (DATA_WIDTH+3)*CLKS_PER_BIT.
- Undefined: no parity bit; 8N1 exactly as above.

Test Plan:
- Reset, CLKS_PER_BIT=4; pulse out_load_i with 0x01 at edge 0 -> tx_o low on cycles 1-4, then bits 1,0,0,0,0,0,0,0 (4 cycles each), stop high 4 cycles; busy_o drops after cycle 40; overflow_o=0.
- Push 0xA5 then 0x3C on consecutive edges -> two frames back-to-back: stop bit of frame 1 is followed immediately by start bit of frame 2; decoded bytes are 0xA5, 0x3C; 80 cycles total.
- Push 6 bytes 0x10..0x15 on consecutive edges (FIFO_DEPTH=4) -> 0x10 popped at edge 1; 0x15 dropped; overflow_o=1 and stays 1; 0x10..0x14 transmitted in order; fifo_full_o high from edge 4 until the first STOP-to-START pop.
- Mid-frame (during DATA bit 3 of 0xFF) assert reset low -> tx_o=1 before the next clk edge; FIFO empty; busy_o=0; after release, no residual frame appears.
- Integration: computer running the LDI #0 / JZ / LDI #1 / JZ / OUTA / HLT program -> exactly one frame with payload 0x01 on tx_o after OUTA; no further frames after HLT.
- With OUT_TX_PARITY_EN, push 0x07 -> parity bit = 1 appears after data bit 7; frame is 44 cycles. Push 0x03 -> parity bit = 0.
